// File: rtl/arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// The byte-lane helpers assume a 32-bit data word with 4 byte lanes.
package arb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_state_e;

  localparam logic [31:0] BWEB_READ = 32'hFFFF_FFFF;

  // Active-high byte enables to active-low SRAM bit write enables.
  function automatic logic [31:0] expand_bweb(input logic [3:0] we);
    logic [31:0] m;
    m = BWEB_READ;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{~we[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// CPU-side (IF and DM) and SRAM-side signals of the port arbiter.
// slave: the arbiter's view. master: the CPU/SRAM environment's view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              sram_ceb;
  logic              sram_web;
  logic [DATA_W-1:0] sram_bweb;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_do,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output sram_ceb, sram_web, sram_bweb, sram_a, sram_di
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_do,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  sram_ceb, sram_web, sram_bweb, sram_a, sram_di
  );
endinterface

// File: rtl/arb_grant_logic.sv
// Grant selection between IF and DM for the shared SRAM port.
// ARB_RR_EN defined: round-robin on contention via a 1-bit last_gnt register.
// ARB_RR_EN undefined: DM has priority, IF forced through after STARVE_MAX
// consecutive denied cycles.
module arb_grant_logic #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX must lie in 1..15");
  end

  logic if_win;

`ifdef ARB_RR_EN
  logic last_gnt;  // 0 = IF granted last, 1 = DM granted last

  // On contention the port not served last goes first.
  always_comb begin
    if_win = !dm_req || last_gnt;
  end

  // Remember the most recent winner.
  always_ff @(posedge clk) begin
    if (rst)         last_gnt <= 1'b0;
    else if (if_gnt) last_gnt <= 1'b0;
    else if (dm_gnt) last_gnt <= 1'b1;
  end
`else
  logic [3:0] starve_cnt;

  // DM wins unless IF has been held off long enough.
  always_comb begin
    if_win = !dm_req || (starve_cnt == 4'(STARVE_MAX));
  end

  // Count consecutive cycles IF waits; saturates at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst || !if_req || if_gnt)          starve_cnt <= 4'd0;
    else if (starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  assign if_gnt = !rst && if_req && if_win;
  assign dm_gnt = !rst && dm_req && !if_gnt;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between CPU IF and DM ports.
// Optional macro ARB_RR_EN switches arbitration to round-robin.
//
// resp_state | meaning
// RESP_NONE  | no read in flight, both rvalids low
// RESP_IF    | IF read issued last cycle, sram_do belongs to IF
// RESP_DM    | DM read issued last cycle, sram_do belongs to DM
module sram_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  sram_port_arbiter_if.slave bus
);

  resp_state_e       resp_state, resp_next;
  logic              if_gnt, dm_gnt, dm_wr;
  logic              ceb, web;
  logic [DATA_W-1:0] bweb, di;
  logic [ADDR_W-1:0] addr;
  logic              if_rvalid, dm_rvalid;

  arb_grant_logic #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  assign dm_wr = dm_gnt && (bus.dm_we != 4'b0000);

  // Drive the SRAM from whichever port holds the grant this cycle.
  always_comb begin
    ceb  = 1'b1;
    web  = 1'b1;
    bweb = DATA_W'(BWEB_READ);
    addr = '0;
    di   = '0;
    if (if_gnt) begin
      ceb  = 1'b0;
      addr = bus.if_addr;
    end else if (dm_gnt) begin
      ceb  = 1'b0;
      addr = bus.dm_addr;
      di   = bus.dm_wdata;
      if (dm_wr) begin
        web  = 1'b0;
        bweb = DATA_W'(expand_bweb(bus.dm_we));
      end
    end
  end

  // Next response owner follows this cycle's grant; writes return nothing.
  always_comb begin
    resp_next = RESP_NONE;
    if (if_gnt)                resp_next = RESP_IF;
    else if (dm_gnt && !dm_wr) resp_next = RESP_DM;
  end

  // Response state register; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) resp_state <= RESP_NONE;
    else     resp_state <= resp_next;
  end

  // Steer sram_do to the owning port as a single-cycle pulse.
  always_comb begin
    if_rvalid = !rst && (resp_state == RESP_IF);
    dm_rvalid = !rst && (resp_state == RESP_DM);
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.sram_do : '0;
  assign bus.dm_rdata  = dm_rvalid ? bus.sram_do : '0;
  assign bus.sram_ceb  = ceb;
  assign bus.sram_web  = web;
  assign bus.sram_bweb = bweb;
  assign bus.sram_a    = addr;
  assign bus.sram_di   = di;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: behavioural SRAM plus a
// transaction-level reference model of grants, memory contents and responses.
module tb_sram_port_arbiter;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 16) return 32'hFFFF_FFFF;
    return 32'hAAAA_0000 | DATA_W'(i);
  endfunction

  // Behavioural SRAM macro driven only by the DUT's SRAM pins.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
      mem_ready = 1'b1;
    end
    if (!bus.sram_ceb) begin
      if (!bus.sram_web)
        mem[bus.sram_a] = (mem[bus.sram_a] & bus.sram_bweb) | (bus.sram_di & ~bus.sram_bweb);
      else
        bus.sram_do = mem[bus.sram_a];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                m_deny;      // consecutive cycles IF has been refused
  bit                m_last_dm;   // most recent grant went to DM
  int                m_pend;      // 0 none, 1 IF read, 2 DM read in flight
  logic [DATA_W-1:0] m_pend_data;

  logic              e_if_gnt, e_dm_gnt, e_ceb, e_web;
  logic [DATA_W-1:0] e_bweb, e_di;
  logic [ADDR_W-1:0] e_a;
  logic              e_if_rvalid, e_dm_rvalid;
  logic [DATA_W-1:0] e_if_rdata, e_dm_rdata;

  // Apply one cycle of inputs, derive this cycle's expected outputs, advance the model.
  task automatic drive(input logic r, input logic ifr, input logic [ADDR_W-1:0] ifa,
                       input logic dmr, input logic [3:0] we, input logic [ADDR_W-1:0] dma,
                       input logic [DATA_W-1:0] wd);
    logic gi, gd;
    @(negedge clk);
    rst = r;
    bus.if_req = ifr; bus.if_addr = ifa;
    bus.dm_req = dmr; bus.dm_we = we; bus.dm_addr = dma; bus.dm_wdata = wd;
    #1;
    e_if_rvalid = !r && (m_pend == 1);
    e_dm_rvalid = !r && (m_pend == 2);
    e_if_rdata  = e_if_rvalid ? m_pend_data : '0;
    e_dm_rdata  = e_dm_rvalid ? m_pend_data : '0;
    gi = 1'b0; gd = 1'b0;
    if (!r) begin
      if (ifr && dmr) begin
`ifdef ARB_RR_EN
        gi = m_last_dm;
`else
        gi = (m_deny == STARVE_MAX);
`endif
        gd = !gi;
      end else begin
        gi = ifr;
        gd = dmr;
      end
    end
    e_if_gnt = gi;
    e_dm_gnt = gd;
    e_ceb    = !(gi || gd);
    e_web    = !(gd && we != 4'b0000);
    e_bweb   = '1;
    for (int i = 0; i < 4; i++) if (gd && we[i]) e_bweb[8*i +: 8] = 8'h00;
    e_a  = gi ? ifa : (gd ? dma : '0);
    e_di = gd ? wd : '0;
    if (r) begin
      m_pend = 0; m_deny = 0; m_last_dm = 1'b0;
    end else begin
      m_pend = 0;
      if (gi) begin
        m_pend = 1; m_pend_data = ref_mem[ifa];
      end else if (gd && we == 4'b0000) begin
        m_pend = 2; m_pend_data = ref_mem[dma];
      end else if (gd) begin
        for (int i = 0; i < 4; i++) if (we[i]) ref_mem[dma][8*i +: 8] = wd[8*i +: 8];
      end
      if (ifr && !gi) m_deny = (m_deny < STARVE_MAX) ? m_deny + 1 : m_deny;
      else            m_deny = 0;
      if (gi)      m_last_dm = 1'b0;
      else if (gd) m_last_dm = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 14'd5, 1'b1, 4'h0, 14'd6, 32'h0);
      n_checks++;
      if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0) begin
        n_errors++; $display("FAIL reset_gnt: if_gnt=%b dm_gnt=%b required 0 0", bus.if_gnt, bus.dm_gnt);
      end
      n_checks++;
      if (bus.sram_ceb !== 1'b1 || bus.sram_web !== 1'b1 || bus.sram_bweb !== 32'hFFFF_FFFF ||
          bus.sram_a !== 14'd0 || bus.sram_di !== 32'd0) begin
        n_errors++;
        $display("FAIL reset_sram: ceb=%b web=%b bweb=%h a=%h di=%h required 1 1 ffffffff 0000 00000000",
                 bus.sram_ceb, bus.sram_web, bus.sram_bweb, bus.sram_a, bus.sram_di);
      end
      n_checks++;
      if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0 || bus.if_rdata !== 32'd0 || bus.dm_rdata !== 32'd0) begin
        n_errors++; $display("FAIL reset_resp: if_rvalid=%b dm_rvalid=%b required 0 0", bus.if_rvalid, bus.dm_rvalid);
      end
    end
    drive(1'b0, 1'b1, 14'd5, 1'b1, 4'h0, 14'd6, 32'h0);
    n_checks++;
    if (bus.dm_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
      n_errors++; $display("FAIL first_gnt: if_gnt=%b dm_gnt=%b required 0 1", bus.if_gnt, bus.dm_gnt);
    end
    n_checks++;
    if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL first_resp: if_rvalid=%b dm_rvalid=%b required 0 0", bus.if_rvalid, bus.dm_rvalid);
    end
    drive(1'b0, 1'b0, 14'd0, 1'b0, 4'h0, 14'd0, 32'h0);
    n_checks++;
    if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hAAAA_0006) begin
      n_errors++; $display("FAIL first_read: dm_rvalid=%b dm_rdata=%h required 1 aaaa0006", bus.dm_rvalid, bus.dm_rdata);
    end
  endtask

  task automatic test_if_back_to_back();
    logic [DATA_W-1:0] want [0:3];
    logic              vld  [0:3];
    want[0] = 32'h0; want[1] = 32'hAAAA_0000; want[2] = 32'hAAAA_0001; want[3] = 32'h0;
    vld[0] = 1'b0; vld[1] = 1'b1; vld[2] = 1'b1; vld[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive(1'b0, 1'b1, 14'(c), 1'b0, 4'h0, 14'd0, 32'h0);
      else       drive(1'b0, 1'b0, 14'd0, 1'b0, 4'h0, 14'd0, 32'h0);
      n_checks++;
      if (bus.if_gnt !== e_if_gnt || bus.sram_a !== e_a || bus.sram_ceb !== e_ceb) begin
        n_errors++; $display("FAIL if_b2b_gnt[%0d]: if_gnt=%b a=%h ceb=%b required %b %h %b",
                             c, bus.if_gnt, bus.sram_a, bus.sram_ceb, e_if_gnt, e_a, e_ceb);
      end
      n_checks++;
      if (bus.if_rvalid !== vld[c] || bus.if_rdata !== want[c] || bus.dm_rvalid !== 1'b0) begin
        n_errors++; $display("FAIL if_b2b_resp[%0d]: if_rvalid=%b if_rdata=%h dm_rvalid=%b required %b %h 0",
                             c, bus.if_rvalid, bus.if_rdata, bus.dm_rvalid, vld[c], want[c]);
      end
    end
  endtask

  task automatic test_dm_write_read();
    drive(1'b0, 1'b0, 14'd0, 1'b1, 4'b0011, 14'h0010, 32'h1234_5678);
    n_checks++;
    if (bus.dm_gnt !== 1'b1 || bus.sram_web !== 1'b0 || bus.sram_bweb !== 32'hFFFF_0000 ||
        bus.sram_a !== 14'h0010 || bus.sram_di !== 32'h1234_5678) begin
      n_errors++; $display("FAIL dm_write_drive: gnt=%b web=%b bweb=%h a=%h di=%h required 1 0 ffff0000 0010 12345678",
                           bus.dm_gnt, bus.sram_web, bus.sram_bweb, bus.sram_a, bus.sram_di);
    end
    drive(1'b0, 1'b0, 14'd0, 1'b1, 4'b0000, 14'h0010, 32'hDEAD_BEEF);
    n_checks++;
    if (bus.dm_rvalid !== 1'b0 || bus.sram_web !== 1'b1 || bus.sram_bweb !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL dm_read_drive: dm_rvalid=%b web=%b bweb=%h required 0 1 ffffffff",
                           bus.dm_rvalid, bus.sram_web, bus.sram_bweb);
    end
    drive(1'b0, 1'b0, 14'd0, 1'b0, 4'h0, 14'd0, 32'h0);
    n_checks++;
    if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hFFFF_5678 || bus.if_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL dm_readback: dm_rvalid=%b dm_rdata=%h if_rvalid=%b required 1 ffff5678 0",
                           bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid);
    end
  endtask

  task automatic test_contention();
    logic want_if;
    drive(1'b1, 1'b0, 14'd0, 1'b0, 4'h0, 14'd0, 32'h0);
    for (int c = 0; c < 21; c++) begin
      drive(1'b0, 1'b1, 14'(32 + c), 1'b1, 4'h0, 14'(64 + c), 32'h0);
`ifdef ARB_RR_EN
      want_if = (c % 2) == 1;
`else
      want_if = (c % (STARVE_MAX + 1)) == STARVE_MAX;
`endif
      n_checks++;
      if (bus.if_gnt !== want_if || bus.dm_gnt !== !want_if) begin
        n_errors++; $display("FAIL contention_gnt[%0d]: if_gnt=%b dm_gnt=%b required %b %b",
                             c, bus.if_gnt, bus.dm_gnt, want_if, !want_if);
      end
      n_checks++;
      if (bus.if_rvalid !== e_if_rvalid || bus.if_rdata !== e_if_rdata ||
          bus.dm_rvalid !== e_dm_rvalid || bus.dm_rdata !== e_dm_rdata) begin
        n_errors++; $display("FAIL contention_resp[%0d]: if=%b/%h dm=%b/%h required %b/%h %b/%h", c,
                             bus.if_rvalid, bus.if_rdata, bus.dm_rvalid, bus.dm_rdata,
                             e_if_rvalid, e_if_rdata, e_dm_rvalid, e_dm_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 14'd3, 1'b0, 4'h0, 14'd0, 32'h0);
    n_checks++;
    if (bus.if_gnt !== 1'b1) begin
      n_errors++; $display("FAIL mid_reset_gnt: if_gnt=%b required 1", bus.if_gnt);
    end
    for (int c = 0; c < 2; c++) begin
      drive(c == 0, 1'b0, 14'd0, 1'b0, 4'h0, 14'd0, 32'h0);
      n_checks++;
      if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'd0 || bus.dm_rvalid !== 1'b0) begin
        n_errors++; $display("FAIL mid_reset_resp[%0d]: if_rvalid=%b if_rdata=%h dm_rvalid=%b required 0 0 0",
                             c, bus.if_rvalid, bus.if_rdata, bus.dm_rvalid);
      end
    end
  endtask

  task automatic test_random();
    logic              r, ifr, dmr;
    logic [3:0]        we;
    for (int c = 0; c < 400; c++) begin
      r   = ($urandom_range(0, 59) == 0);
      ifr = 1'($urandom_range(0, 1));
      dmr = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(r, ifr, 14'($urandom_range(0, 31)), dmr, we, 14'($urandom_range(0, 31)), $urandom);
      n_checks++;
      if (bus.if_gnt !== e_if_gnt || bus.dm_gnt !== e_dm_gnt) begin
        n_errors++; $display("FAIL rand_gnt[%0d]: if_gnt=%b dm_gnt=%b required %b %b",
                             c, bus.if_gnt, bus.dm_gnt, e_if_gnt, e_dm_gnt);
      end
      n_checks++;
      if (bus.sram_ceb !== e_ceb || bus.sram_web !== e_web || bus.sram_bweb !== e_bweb ||
          bus.sram_a !== e_a || (!e_if_gnt && bus.sram_di !== e_di)) begin
        n_errors++; $display("FAIL rand_sram[%0d]: ceb=%b web=%b bweb=%h a=%h di=%h required %b %b %h %h %h", c,
                             bus.sram_ceb, bus.sram_web, bus.sram_bweb, bus.sram_a, bus.sram_di,
                             e_ceb, e_web, e_bweb, e_a, e_di);
      end
      n_checks++;
      if (bus.if_rvalid !== e_if_rvalid || bus.if_rdata !== e_if_rdata ||
          bus.dm_rvalid !== e_dm_rvalid || bus.dm_rdata !== e_dm_rdata) begin
        n_errors++; $display("FAIL rand_resp[%0d]: if=%b/%h dm=%b/%h required %b/%h %b/%h", c,
                             bus.if_rvalid, bus.if_rdata, bus.dm_rvalid, bus.dm_rdata,
                             e_if_rvalid, e_if_rdata, e_dm_rvalid, e_dm_rdata);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_deny = 0; m_last_dm = 1'b0; m_pend = 0; m_pend_data = '0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 4'h0; bus.dm_addr = '0; bus.dm_wdata = '0;
    test_reset();
    test_if_back_to_back();
    test_dm_write_read();
    test_contention();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM_wrapper macro, with 1-cycle read latency, between the CPU instruction-fetch port (IF) and data-memory port (DM).
- Issues at most one SRAM access per cycle, routes the returned read data to the owner, and guarantees IF forward progress.
- Sits between the CPU and a unified IM/DM SRAM instance inside top.

Parameters:
- ADDR_W, 14, SRAM word-address width; matches the PC/ALU-out [15:2] word index.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, maximum consecutive cycles IF may be denied before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  IF read request.
- if_addr  in  ADDR_W  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  if_rdata valid, one cycle after grant.
- if_rdata  out  DATA_W  IF read data.
- dm_req  in  1  DM request.
- dm_we  in  4  byte write enables, active-high; 4'b0000 means read.
- dm_addr  in  ADDR_W  DM word address.
- dm_wdata  in  DATA_W  DM write data.
- dm_gnt  out  1  DM request accepted this cycle.
- dm_rvalid  out  1  dm_rdata valid, one cycle after a granted read.
- dm_rdata  out  DATA_W  DM read data.
- sram_ceb  out  1  SRAM chip enable, active-low.
- sram_web  out  1  SRAM write enable, active-low.
- sram_bweb  out  DATA_W  SRAM bit write enables, active-low.
- sram_a  out  ADDR_W  SRAM address.
- sram_di  out  DATA_W  SRAM write data.
- sram_do  in  DATA_W  SRAM read data, valid the cycle after the access.

Behaviour:
- Reset (rst high at edge):
  - clears resp_state to RESP_NONE and starve_cnt to 0.
  - While rst is high: if_gnt = dm_gnt = 0, sram_ceb = 1, sram_web = 1, sram_bweb = all ones, sram_a = 0, sram_di = 0, rvalids = 0, rdatas = 0.
- Grant is combinational, same cycle as request; a request is accepted iff req & gnt, and the SRAM is driven in that same cycle. At most one gnt high per cycle.
- Arbitration, fixed-priority mode:
  - DM wins by default.
  - IF wins if only IF requests, or if starve_cnt == STARVE_MAX with both requesting.
- starve_cnt:
  - increments when if_req & !if_gnt, saturating at STARVE_MAX.
  - clears to 0 on if_gnt or when if_req is low.
- SRAM drive on an IF grant: sram_ceb = 0, sram_web = 1, sram_bweb = all ones, sram_a = if_addr.
- SRAM drive on a DM grant:
  - sram_a = dm_addr, sram_di = dm_wdata.
  - If dm_we != 0: sram_web = 0 and sram_bweb byte lane i = ~{8{dm_we[i]}}.
  - Otherwise: read encoding, as for IF.
- No grant: sram_ceb = 1, sram_web = 1, sram_bweb = all ones; sram_a and sram_di hold 0.
- Response FSM, resp_state {RESP_NONE, RESP_IF, RESP_DM}, registered, next state from this cycle's grant:
  - IF grant goes to RESP_IF.
  - DM read grant goes to RESP_DM.
  - DM write or no grant goes to RESP_NONE.
- Response outputs:
  - if_rvalid = (resp_state == RESP_IF); dm_rvalid = (resp_state == RESP_DM).
  - rdata = sram_do when the matching rvalid is high, else 0.
  - No backpressure: a response is a single-cycle pulse.
- Back-to-back grants are allowed every cycle (fully pipelined). Throughput is 1 access/cycle.
- A DM write followed by a DM read to the same address on the next cycle returns the new data, per SRAM semantics.
- Reset asserted mid-operation: an in-flight response is dropped, and rvalid is 0 in the cycle after the reset edge.
- Address and data are pass-through with no truncation; ADDR_W must match the macro.

Optional Feature:
- ARB_RR_EN defined:
  - Replaces fixed priority and starve_cnt with a 1-bit last_gnt register (reset 0 = IF last).
  - On simultaneous requests, the port not granted last wins.
  - last_gnt updates on every grant.
  - STARVE_MAX is ignored and starve_cnt is not built.
- Undefined: fixed-priority plus starvation counter, as described above.

Decomposition:
- Shared package arb_pkg holds:
  - the resp_state_e enum (RESP_NONE/RESP_IF/RESP_DM);
  - localparam BWEB_READ = all ones;
  - the byte-to-bit enable expansion function.
- One natural sub-module, arb_grant_logic: combinational priority/RR selection plus the starve_cnt/last_gnt register. The top level handles SRAM muxing and the response FSM.

Test Plan:
- Reset with both requests high -> both gnt 0, sram_ceb 1; first cycle after reset, DM granted, no rvalid.
- IF-only reads to 0x0000 and 0x0001 back-to-back (SRAM preloaded 0xAAAA_0000 / 0xAAAA_0001) -> if_gnt 1 both cycles; if_rvalid 1 on the next two cycles with those values.
- DM write dm_we = 4'b0011, addr 0x0010, wdata 0x1234_5678 over 0xFFFF_FFFF, then DM read of 0x0010 -> sram_bweb = 0xFFFF_0000 on the write; read returns 0xFFFF_5678 with dm_rvalid; no dm_rvalid for the write.
- Continuous simultaneous requests, STARVE_MAX = 4, fixed mode -> DM granted 4 cycles, IF granted on the 5th, pattern repeats; rdata is never delivered to the wrong port.
- Same stimulus with ARB_RR_EN -> grants alternate DM, IF, DM, IF starting from DM.
- rst asserted in the cycle after an IF grant -> if_rvalid stays 0, resp_state returns to RESP_NONE.
